// File: rtl/line_window_ctrl.sv
// Two-line buffer controller for the Sobel datapath. It streams raster pixels through a
// dual-read RAM and emits one vertical column {row y-2, row y-1, row y} per input pixel.
module line_window_ctrl #(
  parameter int PIXEL_W = 8,
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480,
  localparam int XW = (LINE_W  > 1) ? $clog2(LINE_W)  : 1,
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [PIXEL_W-1:0]   s_pix_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [3*PIXEL_W-1:0] m_col_o,
  output logic [XW-1:0]        m_x_o,
  output logic [YW-1:0]        m_y_o,
  output logic                 ram_wr_en_o,
  output logic [XW-1:0]        ram_wr_addr_o,
  output logic [2*PIXEL_W-1:0] ram_wr_data_o,
  output logic                 ram_rd_en_a_o,
  output logic [XW-1:0]        ram_rd_addr_a_o,
  input  logic [2*PIXEL_W-1:0] ram_rd_data_a_i,
  output logic                 ram_rd_en_b_o,
  output logic [XW-1:0]        ram_rd_addr_b_o
);

  logic [XW-1:0]        x_cnt_q, x_cnt_d;
  logic [YW-1:0]        y_cnt_q, y_cnt_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [PIXEL_W-1:0]   s1_pix_q, s1_pix_d;
  logic [XW-1:0]        s1_x_q, s1_x_d;
  logic [YW-1:0]        s1_y_q, s1_y_d;
  logic                 m_valid_q, m_valid_d;
  logic [3*PIXEL_W-1:0] m_col_q, m_col_d;
  logic [XW-1:0]        m_x_q, m_x_d;
  logic [YW-1:0]        m_y_q, m_y_d;
  logic                 advance, accept, load_m;

  always_comb begin
    advance   = !m_valid_q || m_ready_i;
    s_ready_o = !s1_valid_q || advance;
    accept    = rstn_i && s_valid_i && s_ready_o;
    load_m    = rstn_i && s1_valid_q && advance;

    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    s1_valid_d = s1_valid_q;
    s1_pix_d   = s1_pix_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    m_valid_d  = m_valid_q;
    m_col_d    = m_col_q;
    m_x_d      = m_x_q;
    m_y_d      = m_y_q;

    // S1: the RAM read for x_cnt is issued now and its data lands alongside this slot
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_pix_d   = s_pix_i;
      s1_x_d     = x_cnt_q;
      s1_y_d     = y_cnt_q;
      if (x_cnt_q == XW'(LINE_W - 1)) begin
        x_cnt_d = '0;
        y_cnt_d = (y_cnt_q == YW'(FRAME_H - 1)) ? '0 : y_cnt_q + 1'b1;
      end else begin
        x_cnt_d = x_cnt_q + 1'b1;
      end
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    // M: column assembly; the same cycle shifts the column down one row in the RAM
    if (advance) begin
      m_valid_d = s1_valid_q;
    end
    if (load_m) begin
      m_col_d = {ram_rd_data_a_i, s1_pix_q};
      m_x_d   = s1_x_q;
      m_y_d   = s1_y_q;
    end

    ram_rd_en_a_o   = accept;
    ram_rd_addr_a_o = accept ? x_cnt_q : '0;
    ram_wr_en_o     = load_m;
    ram_wr_addr_o   = load_m ? s1_x_q : '0;
    ram_wr_data_o   = load_m ? {ram_rd_data_a_i[PIXEL_W-1:0], s1_pix_q} : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      s1_valid_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_col_q    <= '0;
      m_x_q      <= '0;
      m_y_q      <= '0;
    end else begin
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      s1_valid_q <= s1_valid_d;
      m_valid_q  <= m_valid_d;
      m_col_q    <= m_col_d;
      m_x_q      <= m_x_d;
      m_y_q      <= m_y_d;
    end
  end

  // S1 payload is only meaningful while s1_valid_q is set, so it carries no reset
  always_ff @(posedge clk_i) begin
    s1_pix_q <= s1_pix_d;
    s1_x_q   <= s1_x_d;
    s1_y_q   <= s1_y_d;
  end

  assign m_valid_o       = m_valid_q;
  assign m_col_o         = m_col_q;
  assign m_x_o           = m_x_q;
  assign m_y_o           = m_y_q;
  assign ram_rd_en_b_o   = 1'b0;
  assign ram_rd_addr_b_o = '0;

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl on a 4x4 frame: behavioural RAM, ideal line-buffer model
// with a per-cycle scoreboard, and directed literal checks.
module tb_line_window_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic        s_ready_o;
  logic [7:0]  s_pix;
  logic        m_valid_o;
  logic        m_ready;
  logic [23:0] m_col_o;
  logic [1:0]  m_x_o, m_y_o;
  logic        ram_wr_en_o;
  logic [1:0]  ram_wr_addr_o;
  logic [15:0] ram_wr_data_o;
  logic        ram_rd_en_a_o;
  logic [1:0]  ram_rd_addr_a_o;
  logic        ram_rd_en_b_o;
  logic [1:0]  ram_rd_addr_b_o;
  logic [15:0] rd_q = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  line_window_ctrl #(.PIXEL_W(8), .LINE_W(4), .FRAME_H(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .s_valid_i(s_valid), .s_ready_o(s_ready_o), .s_pix_i(s_pix),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready), .m_col_o(m_col_o),
    .m_x_o(m_x_o), .m_y_o(m_y_o),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_rd_en_a_o(ram_rd_en_a_o), .ram_rd_addr_a_o(ram_rd_addr_a_o), .ram_rd_data_a_i(rd_q),
    .ram_rd_en_b_o(ram_rd_en_b_o), .ram_rd_addr_b_o(ram_rd_addr_b_o)
  );

  // Behavioural sync RAM: registered read that holds when not enabled
  logic [15:0] mem [4];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      mem_init <= 1'b1;
    end else begin
      if (ram_wr_en_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
      if (ram_rd_en_a_o) rd_q <= mem[ram_rd_addr_a_o];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Ideal line buffer: per column, the last two pixels accepted at that x
  typedef struct packed {
    logic [1:0]  x;
    logic [1:0]  y;
    logic [23:0] col;
    logic        k2;
    logic        k1;
  } item_t;

  item_t       q[$];
  item_t       it;
  logic [7:0]  h1 [4] = '{default: 8'h00};
  logic [7:0]  h2 [4] = '{default: 8'h00};
  bit          k1 [4] = '{default: 1'b1};
  bit          k2 [4] = '{default: 1'b1};
  int          n = 0, mx = 0, my = 0;
  bit          exp_ready, acc;
  bit          prev_stall = 0, prev_rst = 0;
  logic [23:0] pcol, mask;
  logic [1:0]  px, py;
  logic [23:0] cap [16];
  logic [1:0]  last_x = '0, last_y = '0;
  logic [23:0] last_col = '0;
  bit          have_last = 0;
  int          wraps = 0;

  always @(negedge clk) begin
    check("port_b_tied", 64'({ram_rd_en_b_o, ram_rd_addr_b_o}), 64'd0);
    if (!rstn) begin
      check("rst_wr_en", 64'(ram_wr_en_o), 64'd0);
      check("rst_rd_en", 64'(ram_rd_en_a_o), 64'd0);
      if (prev_rst) check("rst_m_valid", 64'(m_valid_o), 64'd0);
      if (n > 0) for (int i = 0; i < 4; i++) begin k1[i] = 1'b0; k2[i] = 1'b0; end
      q.delete();
      n = 0; mx = 0; my = 0;
      prev_stall = 0; prev_rst = 1;
    end else begin
      exp_ready = (n < 2) || m_ready;
      check("s_ready", 64'(s_ready_o), 64'(exp_ready));
      acc = s_valid && exp_ready;
      check("rd_en_a", 64'(ram_rd_en_a_o), 64'(acc));
      if (acc) check("rd_addr_a", 64'(ram_rd_addr_a_o), 64'(mx));
      if (prev_stall)
        check("stall_hold", 64'({m_valid_o, m_col_o, m_x_o, m_y_o}), 64'({1'b1, pcol, px, py}));
      if (m_valid_o && q.size() == 0) check("spurious_out", 64'd1, 64'd0);
      if (m_valid_o && m_ready && q.size() > 0) begin
        it = q.pop_front();
        mask = {{8{it.k2}}, {8{it.k1}}, 8'hFF};
        check("col", 64'(m_col_o & mask), 64'(it.col & mask));
        check("xy", 64'({m_x_o, m_y_o}), 64'({it.x, it.y}));
        if (have_last && last_x == 2'd3 && last_y == 2'd3 && m_x_o == 2'd0 && m_y_o == 2'd0)
          wraps++;
        cap[int'(m_y_o) * 4 + int'(m_x_o)] = m_col_o;
        last_x = m_x_o; last_y = m_y_o; last_col = m_col_o; have_last = 1;
        n--;
      end
      if (acc) begin
        it.x = 2'(mx); it.y = 2'(my);
        it.col = {h2[mx], h1[mx], s_pix};
        it.k2 = k2[mx]; it.k1 = k1[mx];
        q.push_back(it);
        h2[mx] = h1[mx]; k2[mx] = k1[mx];
        h1[mx] = s_pix;  k1[mx] = 1'b1;
        n++;
        if (mx == 3) begin mx = 0; my = (my + 1) % 4; end
        else mx++;
      end
      prev_stall = m_valid_o && !m_ready;
      pcol = m_col_o; px = m_x_o; py = m_y_o;
      prev_rst = 0;
    end
  end

  bit rand_rdy = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [7:0] p);
    bit ok;
    int g;
    ok = 0; g = 0;
    s_valid = 1'b1; s_pix = p;
    while (!ok && g < 200) begin
      @(negedge clk); ok = s_ready_o;
      @(posedge clk); #1; g++;
    end
    s_valid = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q.size() != 0 || n != 0) && g < 200) begin @(negedge clk); g++; end
    check("drain", 64'(g < 200), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] held;
    rstn = 1'b0; s_valid = 1'b0; s_pix = '0; m_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check("rst_idle_mvalid", 64'(m_valid_o), 64'd0);
      check("rst_idle_sready", 64'(s_ready_o), 64'd1);
      check("rst_idle_wren", 64'(ram_wr_en_o), 64'd0);
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_mvalid", 64'(m_valid_o), 64'd0);
      check("idle_sready", 64'(s_ready_o), 64'd1);
      check("idle_wren", 64'(ram_wr_en_o), 64'd0);
      @(posedge clk); #1;
    end

    // First pixel: accepted at cycle t, output valid at t+2
    s_valid = 1'b1; s_pix = 8'h00;
    @(negedge clk); check("lat_accept", 64'(s_ready_o), 64'd1);
    @(posedge clk); #1; s_valid = 1'b0;
    @(negedge clk); check("lat_t1_mvalid", 64'(m_valid_o), 64'd0);
    @(negedge clk); check("lat_t2_mvalid", 64'(m_valid_o), 64'd1);
    check("lat_t2_xy", 64'({m_x_o, m_y_o}), 64'd0);
    @(posedge clk); #1;

    for (int i = 1; i < 16; i++) send(8'((i / 4) * 16 + i % 4));
    drain();
    check("col_x2_y2", 64'(cap[10]), 64'h021222);

    // Second frame with a 5-cycle output stall mid-row
    fork
      begin
        for (int i = 0; i < 16; i++) send(8'(8'h80 + (i / 4) * 16 + i % 4));
      end
      begin
        int g;
        g = 0;
        do begin @(negedge clk); g++; end
        while (!(m_valid_o && m_x_o == 2'd1 && m_y_o == 2'd1) && g < 100);
        check("bp_reach", 64'(g < 100), 64'd1);
        @(posedge clk); #1; m_ready = 1'b0;
        @(negedge clk); held = m_col_o;
        check("bp_col", 64'(m_col_o), 64'h328292);
        check("bp_xy", 64'({m_x_o, m_y_o}), 64'({2'd2, 2'd1}));
        repeat (2) @(negedge clk);
        check("bp_sready", 64'(s_ready_o), 64'd0);
        check("bp_rden", 64'(ram_rd_en_a_o), 64'd0);
        repeat (2) @(negedge clk);
        check("bp_held", 64'({m_valid_o, m_col_o, m_x_o, m_y_o}), 64'({1'b1, held, 2'd2, 2'd1}));
        @(posedge clk); #1; m_ready = 1'b1;
      end
    join
    drain();
    check("frame_wrap", 64'(wraps), 64'd1);
    check("f2_row0_x1", 64'(cap[1]), 64'h213181);
    check("f2_row2_x1", 64'(cap[9]), 64'h8191A1);

    // Random valid/ready over three frames
    rand_rdy = 1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(8'($urandom));
      end
    end
    rand_rdy = 0;
    @(posedge clk); #1; m_ready = 1'b1;
    drain();

    // Reset mid-row with x_cnt=2, y=1 and both S1 and M occupied
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
    drain();
    m_ready = 1'b0;
    send(8'h20);
    send(8'h21);
    @(negedge clk);
    check("pre_rst_mvalid", 64'(m_valid_o), 64'd1);
    check("pre_rst_sready", 64'(s_ready_o), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b0; m_ready = 1'b1; s_valid = 1'b1; s_pix = 8'hEE;
    @(posedge clk); #1;
    rstn = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    check("post_rst_mvalid", 64'(m_valid_o), 64'd0);
    check("post_rst_wren", 64'(ram_wr_en_o), 64'd0);
    @(posedge clk); #1;
    send(8'h55);
    drain();
    check("post_rst_tag", 64'({last_x, last_y}), 64'd0);
    check("post_rst_pix", 64'(last_col[7:0]), 64'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
